graph_loader: RTL and testbench



---
 rtl/graph_loader.sv | 241 ++++++++++++++++++++++++
 tb/tb_graph_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/graph_loader.sv
// ---------------------------------------------------------------------------
// mesh_pkg / graph_loader
//
// mesh_pkg holds the node-mesh geometry and packet format shared by the host
// endpoint and the node banks.
//
// graph_loader is the host-side endpoint of the node mesh. It turns an
// edge-list stream into CHILDREN/PARENTS packets for both endpoints of each
// edge. After the list it attaches a host parent edge to the YOU node, fires
// START (seed sum 1) at the OUT node, and captures the SUM packet that comes
// back to the host address.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   go                one-cycle pulse, starts a run from IDLE/DONE
//   edge_valid/ready  edge-list handshake; edge_src, edge_dst, edge_last beat
//   valid_out/ready_out, out_pkt   registered packet stream into the mesh
//   valid_in/ready_in, in_pkt      packet stream from the mesh (always taken)
//   result_valid/result_value      captured path count, held until next go
//   edge_count        edges accepted this run (wraps)
//   err               sticky: self-loop edge or unexpected inbound packet
// ---------------------------------------------------------------------------
package mesh_pkg;
    localparam int MAX_NODES_BITS = 6;
    localparam int MAX_PATHS_BITS = 16;
    localparam int NODES_PER_BANK = 4;
    localparam int MESH_DIMENSION = 4;
    localparam int EDGES_PER_PKT  = 2;

    localparam int Z_W = $clog2(NODES_PER_BANK);
    localparam int Y_W = $clog2(MESH_DIMENSION);
    localparam int X_W = MAX_NODES_BITS - Z_W - Y_W;

    localparam logic [2:0] CTRL_NONE     = 3'd0;
    localparam logic [2:0] CTRL_CHILDREN = 3'd1;
    localparam logic [2:0] CTRL_PARENTS  = 3'd2;
    localparam logic [2:0] CTRL_START    = 3'd3;
    localparam logic [2:0] CTRL_SUM      = 3'd4;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [Z_W-1:0] z;
    } addr_t;

    typedef struct packed {
        logic [MAX_NODES_BITS-1:0] node_id;
    } edge_t;

    typedef struct packed {
        logic [MAX_PATHS_BITS-1:0] value;
    } sum_t;

    typedef struct packed {
        logic [2:0]                    ctrl;
        addr_t                         addr;
        edge_t [EDGES_PER_PKT-1:0]     edges;
        sum_t                          sum;
    } pkt_t;
endpackage

module graph_loader
    import mesh_pkg::*;
#(
    parameter logic [MAX_NODES_BITS-1:0] YOU_ID  = MAX_NODES_BITS'(0),
    parameter logic [MAX_NODES_BITS-1:0] OUT_ID  = MAX_NODES_BITS'(1),
    parameter logic [MAX_NODES_BITS-1:0] HOST_ID = {MAX_NODES_BITS{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      go,
    input  logic                      edge_valid,
    output logic                      edge_ready,
    input  logic [MAX_NODES_BITS-1:0] edge_src,
    input  logic [MAX_NODES_BITS-1:0] edge_dst,
    input  logic                      edge_last,
    output logic                      valid_out,
    input  logic                      ready_out,
    output pkt_t                      out_pkt,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  pkt_t                      in_pkt,
    output logic                      result_valid,
    output logic [MAX_PATHS_BITS-1:0] result_value,
    output logic [MAX_NODES_BITS-1:0] edge_count,
    output logic                      err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_EDGE   = 3'd1;
    localparam logic [2:0] S_CHILD  = 3'd2;
    localparam logic [2:0] S_PARENT = 3'd3;
    localparam logic [2:0] S_HOST   = 3'd4;
    localparam logic [2:0] S_START  = 3'd5;
    localparam logic [2:0] S_WAIT   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    function automatic addr_t decode(input logic [MAX_NODES_BITS-1:0] n);
        addr_t a;
        a.x = X_W'(int'(n) / (NODES_PER_BANK * MESH_DIMENSION));
        a.y = Y_W'((int'(n) / NODES_PER_BANK) % MESH_DIMENSION);
        a.z = Z_W'(int'(n) % NODES_PER_BANK);
        return a;
    endfunction

    // Every outbound packet starts from all-zero so unused fields stay 0.
    function automatic pkt_t make_pkt(input logic [2:0]                ctrl,
                                      input addr_t                     addr,
                                      input logic [MAX_NODES_BITS-1:0] node_id,
                                      input logic [MAX_PATHS_BITS-1:0] value);
        pkt_t p;
        p                  = '0;
        p.ctrl             = ctrl;
        p.addr             = addr;
        p.edges[0].node_id = node_id;
        p.sum.value        = value;
        return p;
    endfunction

    logic [2:0]                state;
    logic [MAX_NODES_BITS-1:0] src_q;
    logic [MAX_NODES_BITS-1:0] dst_q;
    logic                      last_q;

    logic  edge_fire;
    logic  go_ok;
    logic  result_hit;
    pkt_t  host_pkt;
    pkt_t  start_pkt;
    addr_t host_addr;
    logic  unused_in;

    assign edge_ready = (state == S_EDGE);
    assign edge_fire  = edge_valid && edge_ready;
    // Inbound side never back-pressures; it only drops while reset is held.
    assign ready_in   = rst;
    assign go_ok      = go && ((state == S_IDLE) || (state == S_DONE));
    assign host_addr  = decode(HOST_ID);
    assign result_hit = valid_in && (state == S_WAIT) &&
                        (in_pkt.ctrl == CTRL_SUM) && (in_pkt.addr == host_addr);
    assign host_pkt   = make_pkt(CTRL_PARENTS, decode(YOU_ID), HOST_ID, '0);
    assign start_pkt  = make_pkt(CTRL_START, decode(OUT_ID), '0, MAX_PATHS_BITS'(1));
    assign unused_in  = ^in_pkt.edges;

    // Edge beat holding registers: only meaningful after a handshake.
    always_ff @(posedge clk) begin
        if (edge_fire) begin
            src_q  <= edge_src;
            dst_q  <= edge_dst;
            last_q <= edge_last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            valid_out    <= 1'b0;
            out_pkt      <= '0;
            result_valid <= 1'b0;
            result_value <= '0;
            edge_count   <= '0;
            err          <= 1'b0;
        end else begin
            if (go_ok) begin
                state        <= S_EDGE;
                result_valid <= 1'b0;
                result_value <= '0;
                edge_count   <= '0;
                err          <= 1'b0;
            end

            case (state)
                S_EDGE: begin
                    if (edge_valid) begin
                        edge_count <= edge_count + MAX_NODES_BITS'(1);
                        if (edge_src == edge_dst) begin
                            // Self-loop: counted but produces no packets.
                            err <= 1'b1;
                            if (edge_last) begin
                                state     <= S_HOST;
                                valid_out <= 1'b1;
                                out_pkt   <= host_pkt;
                            end
                        end else begin
                            state     <= S_CHILD;
                            valid_out <= 1'b1;
                            out_pkt   <= make_pkt(CTRL_CHILDREN, decode(edge_src),
                                                  edge_dst, '0);
                        end
                    end
                end
                S_CHILD: begin
                    if (ready_out) begin
                        state   <= S_PARENT;
                        out_pkt <= make_pkt(CTRL_PARENTS, decode(dst_q), src_q, '0);
                    end
                end
                S_PARENT: begin
                    if (ready_out) begin
                        if (last_q) begin
                            state   <= S_HOST;
                            out_pkt <= host_pkt;
                        end else begin
                            state     <= S_EDGE;
                            valid_out <= 1'b0;
                            out_pkt   <= '0;
                        end
                    end
                end
                S_HOST: begin
                    if (ready_out) begin
                        state   <= S_START;
                        out_pkt <= start_pkt;
                    end
                end
                S_START: begin
                    if (ready_out) begin
                        state     <= S_WAIT;
                        valid_out <= 1'b0;
                        out_pkt   <= '0;
                    end
                end
                default: ;
            endcase

            // Inbound packets are always consumed; anything but the expected
            // result is flagged and dropped. Placed last so a stray packet
            // arriving with go still leaves err set.
            if (valid_in) begin
                if (result_hit) begin
                    result_value <= in_pkt.sum.value;
                    result_valid <= 1'b1;
                    state        <= S_DONE;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_graph_loader.sv
module tb_graph_loader;
    import mesh_pkg::*;

    localparam int YOU  = 0;
    localparam int OUTN = 1;
    localparam int HOST = 63;

    logic                      clk;
    logic                      rst;
    logic                      go;
    logic                      edge_valid;
    logic                      edge_ready;
    logic [MAX_NODES_BITS-1:0] edge_src;
    logic [MAX_NODES_BITS-1:0] edge_dst;
    logic                      edge_last;
    logic                      valid_out;
    logic                      ready_out;
    pkt_t                      out_pkt;
    logic                      valid_in;
    logic                      ready_in;
    pkt_t                      in_pkt;
    logic                      result_valid;
    logic [MAX_PATHS_BITS-1:0] result_value;
    logic [MAX_NODES_BITS-1:0] edge_count;
    logic                      err;

    graph_loader #(
        .YOU_ID (MAX_NODES_BITS'(YOU)),
        .OUT_ID (MAX_NODES_BITS'(OUTN)),
        .HOST_ID(MAX_NODES_BITS'(HOST))
    ) dut (
        .clk(clk), .rst(rst), .go(go),
        .edge_valid(edge_valid), .edge_ready(edge_ready),
        .edge_src(edge_src), .edge_dst(edge_dst), .edge_last(edge_last),
        .valid_out(valid_out), .ready_out(ready_out), .out_pkt(out_pkt),
        .valid_in(valid_in), .ready_in(ready_in), .in_pkt(in_pkt),
        .result_valid(result_valid), .result_value(result_value),
        .edge_count(edge_count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;   // 0: tied high, 1: random 30%, 2: driven by hand
    pkt_t got_q[$];
    pkt_t exp_q[$];
    int   src_a[80];
    int   dst_a[80];

    typedef struct {
        int src;
        int dst;
        int rmode;
        int sum_val;
        int exp_result;
        int exp_err;
        int exp_count;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pkt(input string name, input pkt_t act, input pkt_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ctrl=%0d addr=%0h id=%0d val=%0d expected ctrl=%0d addr=%0h id=%0d val=%0d",
                     name, act.ctrl, act.addr, act.edges[0].node_id, act.sum.value,
                     exp.ctrl, exp.addr, exp.edges[0].node_id, exp.sum.value);
        end
    endtask

    // Reference packet: node address from the mesh geometry, all else zero.
    function automatic pkt_t mk(input logic [2:0] c, input int node, input int id, input int val);
        pkt_t p;
        p                  = '0;
        p.ctrl             = c;
        p.addr.x           = X_W'(node / (NODES_PER_BANK * MESH_DIMENSION));
        p.addr.y           = Y_W'((node / NODES_PER_BANK) % MESH_DIMENSION);
        p.addr.z           = Z_W'(node % NODES_PER_BANK);
        p.edges[0].node_id = MAX_NODES_BITS'(id);
        p.sum.value        = MAX_PATHS_BITS'(val);
        return p;
    endfunction

    // Expected outbound stream for an edge list.
    task automatic build_model(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (src_a[i] != dst_a[i]) begin
                exp_q.push_back(mk(CTRL_CHILDREN, src_a[i], dst_a[i], 0));
                exp_q.push_back(mk(CTRL_PARENTS, dst_a[i], src_a[i], 0));
            end
        end
        exp_q.push_back(mk(CTRL_PARENTS, YOU, HOST, 0));
        exp_q.push_back(mk(CTRL_START, OUTN, 0, 1));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) ready_out = 1'b1;
            else if (ready_mode == 1) ready_out = ($urandom_range(0, 99) < 30);
        end
    end

    // Packet monitor plus hold-while-stalled check.
    bit   stall_prev = 1'b0;
    pkt_t stall_pkt;
    always @(negedge clk) begin
        if (rst && stall_prev) begin
            checks++;
            if (!valid_out || out_pkt !== stall_pkt) begin
                errors++;
                $display("FAIL stall_hold: got valid=%0b pkt=%0h expected valid=1 pkt=%0h",
                         valid_out, out_pkt, stall_pkt);
            end
        end
        stall_prev = rst && valid_out && !ready_out;
        stall_pkt  = out_pkt;
        if (rst && valid_out && ready_out) got_q.push_back(out_pkt);
    end

    task automatic start_run();
        got_q.delete();
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic drive_edges(input int n);
        bit ok;
        int waited;
        for (int i = 0; i < n; i++) begin
            edge_valid = 1'b1;
            edge_src   = MAX_NODES_BITS'(src_a[i]);
            edge_dst   = MAX_NODES_BITS'(dst_a[i]);
            edge_last  = (i == n - 1);
            ok = 1'b0;
            waited = 0;
            while (!ok && waited < 200) begin
                @(negedge clk);
                if (edge_ready) ok = 1'b1;
                else begin @(posedge clk); #1; end
                waited++;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL edge_accept: edge %0d not accepted, required within 200 cycles", i);
            end
            @(posedge clk); #1;
            edge_valid = 1'b0;
        end
    endtask

    task automatic compare_stream(input string tag);
        int budget;
        budget = 0;
        while (got_q.size() < exp_q.size() && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_pkt_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_pkt($sformatf("%s_pkt%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, "_valid_out_idle"}, 64'(valid_out), 64'(0));
        check({tag, "_edge_ready_wait"}, 64'(edge_ready), 64'(0));
    endtask

    task automatic send_in(input logic [2:0] c, input int node, input int val);
        valid_in = 1'b1;
        in_pkt   = mk(c, node, 0, val);
        @(posedge clk); #1;
        valid_in = 1'b0;
        in_pkt   = '0;
    endtask

    task automatic full_run(input string tag, input int n, input int sum_val,
                            input int exp_count, input int exp_err);
        start_run();
        drive_edges(n);
        build_model(n);
        compare_stream(tag);
        check({tag, "_edge_count"}, 64'(edge_count), 64'(exp_count));
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        check({tag, "_result_valid_before"}, 64'(result_valid), 64'(0));
        send_in(CTRL_SUM, HOST, sum_val);
        check({tag, "_result_valid"}, 64'(result_valid), 64'(1));
        check({tag, "_result_value"}, 64'(result_value), 64'(sum_val));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid_out"}, 64'(valid_out), 64'(0));
        check({tag, "_out_pkt"}, 64'(out_pkt), 64'(0));
        check({tag, "_edge_ready"}, 64'(edge_ready), 64'(0));
        check({tag, "_ready_in"}, 64'(ready_in), 64'(0));
        check({tag, "_result_valid"}, 64'(result_valid), 64'(0));
        check({tag, "_result_value"}, 64'(result_value), 64'(0));
        check({tag, "_edge_count"}, 64'(edge_count), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int e_err;
        int sv;

        //             src dst rmode sum    result err count
        tbl[0] = '{5,  6,  0, 3,     3,     0, 1};
        tbl[1] = '{0,  63, 1, 65535, 65535, 0, 1};
        tbl[2] = '{7,  7,  0, 12,    12,    1, 1};
        tbl[3] = '{63, 0,  1, 1234,  1234,  0, 1};
        tbl[4] = '{20, 41, 0, 0,     0,     0, 1};

        rst = 1'b0; go = 1'b0; edge_valid = 1'b0; edge_src = '0; edge_dst = '0;
        edge_last = 1'b0; ready_out = 1'b1; valid_in = 1'b0; in_pkt = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready_in_after_reset", 64'(ready_in), 64'(1));
        check("edge_ready_idle", 64'(edge_ready), 64'(0));

        // Single-edge table.
        foreach (tbl[k]) begin
            ready_mode = tbl[k].rmode;
            src_a[0] = tbl[k].src;
            dst_a[0] = tbl[k].dst;
            full_run($sformatf("tbl%0d", k), 1, tbl[k].sum_val, tbl[k].exp_count, tbl[k].exp_err);
            check($sformatf("tbl%0d_exp_result", k), 64'(result_value), 64'(tbl[k].exp_result));
        end

        // Self-loop in the middle of three edges.
        ready_mode = 0;
        src_a[0] = 1; dst_a[0] = 2;
        src_a[1] = 4; dst_a[1] = 4;
        src_a[2] = 2; dst_a[2] = 3;
        full_run("selfloop", 3, 77, 3, 1);

        // Random edge lists under random back-pressure.
        for (int r = 0; r < 3; r++) begin
            ready_mode = 1;
            n = 8;
            e_err = 0;
            for (int i = 0; i < n; i++) begin
                src_a[i] = $urandom_range(0, 63);
                dst_a[i] = $urandom_range(0, 63);
                if (src_a[i] == dst_a[i]) e_err = 1;
            end
            sv = $urandom_range(0, 65535);
            full_run($sformatf("rand%0d", r), n, sv, n % 64, e_err);
        end

        // Edge count wraps past 2**MAX_NODES_BITS.
        ready_mode = 0;
        n = 66;
        e_err = 0;
        for (int i = 0; i < n; i++) begin
            src_a[i] = $urandom_range(0, 63);
            dst_a[i] = (src_a[i] + 1 + $urandom_range(0, 61)) % 64;
        end
        full_run("wrap", n, 5, n % 64, e_err);

        // Unexpected inbound packets and go while busy.
        ready_mode = 0;
        start_run();
        send_in(CTRL_SUM, HOST, 9);
        check("stray_sum_err", 64'(err), 64'(1));
        check("stray_sum_still_edge", 64'(edge_ready), 64'(1));
        check("stray_sum_no_result", 64'(result_valid), 64'(0));
        src_a[0] = 10; dst_a[0] = 11;
        drive_edges(1);
        build_model(1);
        compare_stream("stray");
        send_in(CTRL_CHILDREN, HOST, 0);
        check("stray_children_no_result", 64'(result_valid), 64'(0));
        send_in(CTRL_SUM, 3, 7);
        check("wrong_addr_no_result", 64'(result_valid), 64'(0));
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        check("go_in_wait_ignored_ready", 64'(edge_ready), 64'(0));
        check("go_in_wait_ignored_err", 64'(err), 64'(1));
        check("go_in_wait_count", 64'(edge_count), 64'(1));
        send_in(CTRL_SUM, HOST, 42);
        check("late_result_valid", 64'(result_valid), 64'(1));
        check("late_result_value", 64'(result_value), 64'(42));
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        check("go_done_result_valid", 64'(result_valid), 64'(0));
        check("go_done_result_value", 64'(result_value), 64'(0));
        check("go_done_edge_ready", 64'(edge_ready), 64'(1));
        check("go_done_err", 64'(err), 64'(0));
        check("go_done_count", 64'(edge_count), 64'(0));

        // Reset while the parent packet is stalled.
        ready_mode = 2;
        ready_out = 1'b0;
        src_a[0] = 5; dst_a[0] = 6;
        drive_edges(1);
        check_pkt("stall_child", out_pkt, mk(CTRL_CHILDREN, 5, 6, 0));
        ready_out = 1'b1;
        @(posedge clk); #1;
        ready_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("stall_parent_valid", 64'(valid_out), 64'(1));
        check_pkt("stall_parent_pkt", out_pkt, mk(CTRL_PARENTS, 6, 5, 0));
        rst = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midrun_reset_held");
        rst = 1'b1;
        ready_mode = 0;
        @(posedge clk); #1;
        src_a[0] = 5; dst_a[0] = 6;
        src_a[1] = 6; dst_a[1] = 1;
        full_run("after_reset", 2, 3, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
